cgra_config_loader: RTL and testbench



---
 rtl/cgra_config_loader.sv | 191 +++++++++++++++++++
 tb/tb_cgra_config_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_config_loader.sv
// -----------------------------------------------------------------------------
// cgra_config_loader
//
// Purpose:
//   Forwards host configuration commands into the control memory of the
//   addressed CGRA tile, one command at a time. It can also fill every tile's
//   control memory with NOP words through a broadcast "clear" sequence.
//
//   A one-entry command buffer (vld_p0 / cmd_p0) decouples the host from the
//   tile write ports. An accepted command goes out on the first cycle in which
//   both write ports of the target tile are ready. A clear sequence walks the
//   control-memory addresses 0..CTRL_MEM_DEPTH-1. Each address is written to
//   all tiles in the same beat, and a beat is issued only when every tile
//   port is ready.
//
// Ports:
//   clk              sole clock, rising edge
//   reset            synchronous, active-low
//   recv_cmd__en     host command valid (only while recv_cmd__rdy = 1)
//   recv_cmd__msg    {tile_id, addr, cfg}, MSB first
//   recv_cmd__rdy    loader can take a command this cycle
//   clear_start      single-cycle request to NOP-fill all control memories
//   send_waddr__en   per-tile write-address enable
//   send_waddr__msg  per-tile write address
//   send_waddr__rdy  per-tile address-port ready
//   send_wopt__en    per-tile config-word enable
//   send_wopt__msg   per-tile config word
//   send_wopt__rdy   per-tile config-port ready
//   busy             loader not idle or command buffer occupied
//   clear_done       single-cycle pulse in the first idle cycle after a clear
//   sent_count       number of forwarded host commands, saturating
// -----------------------------------------------------------------------------
module cgra_config_loader #(
    parameter int         NUM_TILES      = 16,
    parameter int         CTRL_MEM_DEPTH = 8,
    parameter int         CONFIG_WIDTH   = 49,
    parameter logic [5:0] NOP_CTRL       = 6'h01
) (
    input  logic                                                             clk,
    input  logic                                                             reset,

    input  logic                                                             recv_cmd__en,
    input  logic [$clog2(NUM_TILES)+$clog2(CTRL_MEM_DEPTH)+CONFIG_WIDTH-1:0] recv_cmd__msg,
    output logic                                                             recv_cmd__rdy,

    input  logic                                                             clear_start,

    output logic [NUM_TILES-1:0]                                             send_waddr__en,
    output logic [NUM_TILES-1:0][$clog2(CTRL_MEM_DEPTH)-1:0]                 send_waddr__msg,
    input  logic [NUM_TILES-1:0]                                             send_waddr__rdy,

    output logic [NUM_TILES-1:0]                                             send_wopt__en,
    output logic [NUM_TILES-1:0][CONFIG_WIDTH-1:0]                           send_wopt__msg,
    input  logic [NUM_TILES-1:0]                                             send_wopt__rdy,

    output logic                                                             busy,
    output logic                                                             clear_done,
    output logic [15:0]                                                      sent_count
);

    localparam int TILE_W = $clog2(NUM_TILES);
    localparam int ADDR_W = $clog2(CTRL_MEM_DEPTH);
    localparam int CMD_W  = TILE_W + ADDR_W + CONFIG_WIDTH;

    // The NOP word carries only its ctrl opcode; every other field is zero.
    localparam logic [CONFIG_WIDTH-1:0] NOP_WORD = {NOP_CTRL, {(CONFIG_WIDTH-6){1'b0}}};
    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(CTRL_MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t             state;
    logic               vld_p0;
    logic [CMD_W-1:0]   cmd_p0;
    logic [ADDR_W-1:0]  clr_addr;

    logic [TILE_W-1:0]       buf_tile;
    logic [ADDR_W-1:0]       buf_addr;
    logic [CONFIG_WIDTH-1:0] buf_cfg;
    logic                    tgt_rdy;
    logic                    all_rdy;
    logic                    fwd_fire;
    logic                    clr_fire;
    logic                    accept;
    logic                    clear_go;

    // Counter increment that sticks at full scale instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---------------------------------------------------------------- p0 ----
    // Host side: the command buffer and its acceptance handshake.
    assign recv_cmd__rdy = !vld_p0 && (state == IDLE);
    assign busy          = (state != IDLE) || vld_p0;

    assign accept   = recv_cmd__en && recv_cmd__rdy;
    // A host command in the same cycle wins over a clear request. The clear
    // request is then dropped rather than remembered.
    assign clear_go = clear_start && !recv_cmd__en && !vld_p0 && (state == IDLE);

    assign buf_tile = cmd_p0[CMD_W-1 -: TILE_W];
    assign buf_addr = cmd_p0[CONFIG_WIDTH +: ADDR_W];
    assign buf_cfg  = cmd_p0[CONFIG_WIDTH-1:0];

    // Payload register carries no reset; only its valid bit does.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_p0 <= recv_cmd__msg;
        end
    end

    // ---------------------------------------------------------------- p1 ----
    // Tile side: the enables are combinational from the registered state and
    // this cycle's ready inputs. A transfer therefore fires in the same cycle
    // in which its target ports become ready.
    assign tgt_rdy  = send_waddr__rdy[buf_tile] && send_wopt__rdy[buf_tile];
    assign all_rdy  = (&send_waddr__rdy) && (&send_wopt__rdy);
    assign fwd_fire = (state == FWD) && vld_p0 && tgt_rdy;
    assign clr_fire = (state == CLEAR) && all_rdy;

    always_comb begin
        send_waddr__en  = '0;
        send_wopt__en   = '0;
        send_waddr__msg = '0;
        send_wopt__msg  = '0;
        for (int t = 0; t < NUM_TILES; t++) begin
            if (clr_fire) begin
                send_waddr__en[t]  = 1'b1;
                send_wopt__en[t]   = 1'b1;
                send_waddr__msg[t] = clr_addr;
                send_wopt__msg[t]  = NOP_WORD;
            end else if (fwd_fire && (buf_tile == TILE_W'(t))) begin
                send_waddr__en[t]  = 1'b1;
                send_wopt__en[t]   = 1'b1;
                send_waddr__msg[t] = buf_addr;
                send_wopt__msg[t]  = buf_cfg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            vld_p0     <= 1'b0;
            clr_addr   <= '0;
            sent_count <= 16'd0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        vld_p0 <= 1'b1;
                        state  <= FWD;
                    end else if (clear_go) begin
                        clr_addr <= '0;
                        state    <= CLEAR;
                    end
                end
                FWD: begin
                    if (fwd_fire) begin
                        vld_p0     <= 1'b0;
                        sent_count <= sat_inc(sent_count);
                        state      <= IDLE;
                    end
                end
                CLEAR: begin
                    if (clr_fire) begin
                        if (clr_addr == LAST_ADDR) begin
                            // The pulse register is set on this edge, so the
                            // pulse shows in the first idle cycle.
                            clr_addr   <= '0;
                            clear_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            clr_addr <= clr_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_config_loader.sv
`timescale 1ns/1ps
module tb_cgra_config_loader;

    localparam logic [48:0] NOP = 49'h1 << 43;

    logic               clk;
    logic               reset;
    logic               recv_cmd__en;
    logic [55:0]        recv_cmd__msg;
    logic               recv_cmd__rdy;
    logic               clear_start;
    logic [15:0]        send_waddr__en;
    logic [15:0][2:0]   send_waddr__msg;
    logic [15:0]        send_waddr__rdy;
    logic [15:0]        send_wopt__en;
    logic [15:0][48:0]  send_wopt__msg;
    logic [15:0]        send_wopt__rdy;
    logic               busy;
    logic               clear_done;
    logic [15:0]        sent_count;

    // Ready sources: manual (directed tests) or random (random phase).
    logic        rand_rdy;
    logic [15:0] man_wa, man_wo, rnd_wa, rnd_wo;
    assign send_waddr__rdy = rand_rdy ? rnd_wa : man_wa;
    assign send_wopt__rdy  = rand_rdy ? rnd_wo : man_wo;

    cgra_config_loader dut (
        .clk             (clk),
        .reset           (reset),
        .recv_cmd__en    (recv_cmd__en),
        .recv_cmd__msg   (recv_cmd__msg),
        .recv_cmd__rdy   (recv_cmd__rdy),
        .clear_start     (clear_start),
        .send_waddr__en  (send_waddr__en),
        .send_waddr__msg (send_waddr__msg),
        .send_waddr__rdy (send_waddr__rdy),
        .send_wopt__en   (send_wopt__en),
        .send_wopt__msg  (send_wopt__msg),
        .send_wopt__rdy  (send_wopt__rdy),
        .busy            (busy),
        .clear_done      (clear_done),
        .sent_count      (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of the tile writes the host has asked
    // for. A forward is one write to one tile. A clear is eight broadcast
    // writes to addresses 0..7.
    typedef struct {
        bit          clr;
        logic [3:0]  tile;
        logic [2:0]  addr;
        logic [48:0] cfg;
    } beat_t;

    beat_t       exp_q[$];
    int          checks;
    int          errors;
    logic [15:0] model_cnt;
    logic        done_next;
    int          clr_beats;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: compares every beat the DUT presents against the model queue.
    beat_t cur;
    logic  other;
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            model_cnt = 16'd0;
            done_next = 1'b0;
        end else begin
            chk("clear_done", clear_done, done_next);
            done_next = 1'b0;
            chk("sent_count", sent_count, model_cnt);
            if (send_waddr__en != 16'd0 || send_wopt__en != 16'd0) begin
                chk("en_pair", send_waddr__en, send_wopt__en);
                chk("en_without_rdy", send_waddr__en & ~(send_waddr__rdy & send_wopt__rdy), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: en=%h, expected no beat (t=%0t)", send_waddr__en, $time);
                end else begin
                    cur = exp_q.pop_front();
                    if (cur.clr) begin
                        chk("clr_en", send_waddr__en, 16'hFFFF);
                        for (int t = 0; t < 16; t++) begin
                            chk("clr_waddr", send_waddr__msg[t], cur.addr);
                            chk("clr_wopt", send_wopt__msg[t], NOP);
                        end
                        if (cur.addr == 3'd7) done_next = 1'b1;
                        clr_beats++;
                    end else begin
                        chk("fwd_en", send_waddr__en, 16'd1 << cur.tile);
                        chk("fwd_waddr", send_waddr__msg[cur.tile], cur.addr);
                        chk("fwd_wopt", send_wopt__msg[cur.tile], cur.cfg);
                        other = 1'b0;
                        for (int t = 0; t < 16; t++)
                            if (t != int'(cur.tile))
                                other = other | (|send_waddr__msg[t]) | (|send_wopt__msg[t]);
                        chk("fwd_others_zero", other, 0);
                        if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
                    end
                end
            end
        end
    end

    // Random ready generator; changes away from both clock edges.
    always @(posedge clk) begin
        int r;
        #2;
        r = $urandom_range(0, 3);
        rnd_wa = 16'hFFFF;
        rnd_wo = 16'hFFFF;
        if (r == 1 || r == 3) rnd_wa[$urandom_range(0, 15)] = 1'b0;
        if (r >= 2)           rnd_wo[$urandom_range(0, 15)] = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd_rdy(output bit ok);
        int w = 0;
        while (!recv_cmd__rdy && w < 300) begin
            cyc();
            w++;
        end
        ok = recv_cmd__rdy;
        if (!ok) fail_now("cmd_rdy_timeout");
    endtask

    task automatic send_cmd(input logic [3:0] tile, input logic [2:0] addr, input logic [48:0] cfg);
        bit ok;
        beat_t b;
        wait_cmd_rdy(ok);
        if (ok) begin
            recv_cmd__en  = 1'b1;
            recv_cmd__msg = {tile, addr, cfg};
            b.clr = 1'b0; b.tile = tile; b.addr = addr; b.cfg = cfg;
            exp_q.push_back(b);
            cyc();
            recv_cmd__en = 1'b0;
            // Enables appear the cycle after acceptance if the target is ready.
            chk("fwd_latency", send_waddr__en[tile] & send_wopt__en[tile],
                send_waddr__rdy[tile] & send_wopt__rdy[tile]);
            chk("cmd_rdy_low_in_fwd", recv_cmd__rdy, 0);
            chk("busy_in_fwd", busy, 1);
        end
    endtask

    task automatic start_clear();
        bit ok;
        beat_t b;
        wait_cmd_rdy(ok);
        if (ok) begin
            clear_start = 1'b1;
            for (int a = 0; a < 8; a++) begin
                b.clr = 1'b1; b.tile = 4'd0; b.addr = 3'(a); b.cfg = NOP;
                exp_q.push_back(b);
            end
            cyc();
            clear_start = 1'b0;
            chk("busy_in_clear", busy, 1);
            chk("cmd_rdy_low_in_clear", recv_cmd__rdy, 0);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((exp_q.size() != 0 || busy) && w < 1000) begin
            cyc();
            w++;
        end
        if (exp_q.size() != 0 || busy) fail_now("idle_timeout");
    endtask

    logic [48:0] cfg35;
    int          base;
    int          w;

    initial begin
        checks = 0; errors = 0; clr_beats = 0;
        model_cnt = 16'd0; done_next = 1'b0;
        reset = 1'b0; recv_cmd__en = 1'b0; recv_cmd__msg = '0; clear_start = 1'b0;
        rand_rdy = 1'b0; man_wa = 16'hFFFF; man_wo = 16'hFFFF;
        rnd_wa = 16'hFFFF; rnd_wo = 16'hFFFF;

        // Reset state
        repeat (3) cyc();
        chk("rst_en_waddr", send_waddr__en, 0);
        chk("rst_en_wopt", send_wopt__en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_sent_count", sent_count, 0);
        reset = 1'b1;
        cyc();
        chk("rst_cmd_rdy", recv_cmd__rdy, 1);

        // Directed forward to tile 5
        cfg35 = {6'h01, 1'b0, 12'd0, 3'd4, 3'd4, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 6'd0};
        send_cmd(4'd5, 3'd0, cfg35);
        cyc(); cyc();
        chk("fwd_sent_count", sent_count, 1);

        // Backpressure on tile 6 config port for 5 cycles
        man_wo[6] = 1'b0;
        send_cmd(4'd6, 3'd2, {$urandom, $urandom} & 49'h1_FFFF_FFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_no_en", send_waddr__en | send_wopt__en, 0);
            chk("bp_cmd_rdy", recv_cmd__rdy, 0);
            cyc();
        end
        man_wo[6] = 1'b1;
        #1;
        chk("bp_en_rise", send_waddr__en[6] & send_wopt__en[6], 1);
        cyc();
        chk("bp_en_once", send_waddr__en | send_wopt__en, 0);
        wait_idle();

        // Full clear with all ready
        start_clear();
        chk("clr_first_beat", send_waddr__en, 16'hFFFF);
        wait_idle();
        cyc();
        chk("clr_sent_count_kept", sent_count, 2);

        // Clear with a stall on tile 15 address port during beat 3
        base = clr_beats;
        start_clear();
        w = 0;
        while (clr_beats < base + 3 && w < 100) begin cyc(); w++; end
        if (clr_beats < base + 3) fail_now("stall_wait");
        man_wa[15] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_no_waddr_en", send_waddr__en, 0);
            chk("stall_no_wopt_en", send_wopt__en, 0);
            cyc();
        end
        man_wa[15] = 1'b1;
        wait_idle();
        chk("stall_beats_total", clr_beats - base, 8);

        // Collision: command and clear in the same cycle
        begin
            beat_t b;
            bit ok;
            wait_cmd_rdy(ok);
            recv_cmd__en  = 1'b1;
            clear_start   = 1'b1;
            recv_cmd__msg = {4'd9, 3'd7, 49'h0_1234_5678_9ABC};
            b.clr = 1'b0; b.tile = 4'd9; b.addr = 3'd7; b.cfg = 49'h0_1234_5678_9ABC;
            exp_q.push_back(b);
            cyc();
            recv_cmd__en = 1'b0;
            clear_start  = 1'b0;
            chk("collide_fwd_en", send_waddr__en, 16'h0200);
            wait_idle();
            repeat (3) cyc();
            chk("collide_no_clear", clr_beats, base + 8);
        end

        // Reset in the middle of a clear
        base = clr_beats;
        start_clear();
        w = 0;
        while (clr_beats < base + 3 && w < 100) begin cyc(); w++; end
        reset = 1'b0;
        cyc();
        chk("midrst_waddr_en", send_waddr__en, 0);
        chk("midrst_wopt_en", send_wopt__en, 0);
        chk("midrst_sent_count", sent_count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_clear_done", clear_done, 0);
        reset = 1'b1;
        repeat (4) cyc();
        chk("midrst_no_done_pulse", clear_done, 0);
        send_cmd(4'd3, 3'd5, 49'h1_5555_AAAA_0F0F);
        wait_idle();

        // Randomized traffic with random ready patterns
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                start_clear();
                wait_idle();
            end else begin
                send_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                         {$urandom, $urandom} & 49'h1_FFFF_FFFF_FFFF);
            end
            repeat ($urandom_range(0, 2)) cyc();
        end
        wait_idle();
        rand_rdy = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
